wishbone_arbiter: RTL

Round-robin arbiter sharing one Wishbone slave port between `N_MASTERS` Wishbone masters, for example a core's instruction and data fetch units feeding a single `wishbone_slave`-fronted memory. It grants the bus for a whole cycle (`cyc` high to `cyc` low) and muxes the winner's request onto the slave side. It routes responses back only to the winner. A watchdog terminates any strobe the slave fails to answer within `TIMEOUT` cycles.

---
 rtl/wishbone_pkg.sv | 32 +++
 rtl/wishbone_arbiter_if.sv | 56 +++++
 rtl/rr_picker.sv | 26 ++
 rtl/wishbone_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// rtl/wishbone_pkg.sv - shared Wishbone request/response types and arbiter state encoding
package wishbone_pkg;

    // Tags are carried at this width internally and trimmed to TAGSIZE at the ports.
    localparam int TAG_MAX = 8;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_e;

    typedef struct packed {
        logic               cyc;
        logic               stb;
        logic               we;
        logic [3:0]         sel;
        logic [31:0]        adr;
        logic [31:0]        dat;
        logic [TAG_MAX-1:0] tga;
        logic [TAG_MAX-1:0] tgc;
        logic [TAG_MAX-1:0] tgd;
    } wb_req_t;

    typedef struct packed {
        logic [31:0]        dat;
        logic [TAG_MAX-1:0] tgd;
        logic               ack;
        logic               err;
        logic               rty;
    } wb_rsp_t;

endpackage

// File: rtl/wishbone_arbiter_if.sv
// rtl/wishbone_arbiter_if.sv - bundle of master-side and slave-side Wishbone signals around the arbiter
interface wishbone_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int TAGSIZE   = 2
);
    logic [N_MASTERS-1:0]         m_cyc_i;
    logic [N_MASTERS-1:0]         m_stb_i;
    logic [N_MASTERS-1:0]         m_we_i;
    logic [4*N_MASTERS-1:0]       m_sel_i;
    logic [32*N_MASTERS-1:0]      m_adr_i;
    logic [32*N_MASTERS-1:0]      m_dat_i;
    logic [TAGSIZE*N_MASTERS-1:0] m_tga_i;
    logic [TAGSIZE*N_MASTERS-1:0] m_tgc_i;
    logic [TAGSIZE*N_MASTERS-1:0] m_tgd_i;
    logic [31:0]                  m_dat_o;
    logic [TAGSIZE-1:0]           m_tgd_o;
    logic [N_MASTERS-1:0]         m_ack_o;
    logic [N_MASTERS-1:0]         m_err_o;
    logic [N_MASTERS-1:0]         m_rty_o;

    logic                         s_cyc_o;
    logic                         s_stb_o;
    logic                         s_we_o;
    logic [3:0]                   s_sel_o;
    logic [31:0]                  s_adr_o;
    logic [31:0]                  s_dat_o;
    logic [TAGSIZE-1:0]           s_tga_o;
    logic [TAGSIZE-1:0]           s_tgc_o;
    logic [TAGSIZE-1:0]           s_tgd_o;
    logic [31:0]                  s_dat_i;
    logic [TAGSIZE-1:0]           s_tgd_i;
    logic                         s_ack_i;
    logic                         s_err_i;
    logic                         s_rty_i;

    logic [N_MASTERS-1:0]         gnt_o;
    logic                         busy_o;

    // The arbiter side of the bundle.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_tga_i, m_tgc_i, m_tgd_i,
        output m_dat_o, m_tgd_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_tga_o, s_tgc_o, s_tgd_o,
        input  s_dat_i, s_tgd_i, s_ack_i, s_err_i, s_rty_i,
        output gnt_o, busy_o
    );

    // The environment side: masters plus the shared slave.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_tga_i, m_tgc_i, m_tgd_i,
        input  m_dat_o, m_tgd_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_tga_o, s_tgc_o, s_tgd_o,
        output s_dat_i, s_tgd_i, s_ack_i, s_err_i, s_rty_i,
        input  gnt_o, busy_o
    );
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search starting just after last_idx
module rr_picker #(
    parameter int N    = 2,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last_idx,
    output logic [IDXW-1:0] idx,
    output logic            valid
);
    logic [IDXW-1:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        // i == N wraps back to last_idx itself, so it is searched last.
        for (int i = 1; i <= N; i++) begin
            cand = IDXW'((int'(last_idx) + i) % N);
            if (!valid && req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - round-robin N-master Wishbone arbiter with strobe watchdog
module wishbone_arbiter
    import wishbone_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int TAGSIZE   = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wishbone_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(N_MASTERS);
    localparam int WDW  = $clog2(TIMEOUT);

    arb_state_e      state, state_nxt;
    logic [IDXW-1:0] grant_idx, grant_nxt;
    logic [IDXW-1:0] last_idx, last_nxt;
    logic [WDW-1:0]  wd_cnt, wd_nxt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;
    logic            wd_fire;
    logic            any_rsp;

    wb_req_t req [N_MASTERS];
    wb_req_t cur;
    wb_rsp_t rsp;

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            req[i].cyc = bus.m_cyc_i[i];
            req[i].stb = bus.m_stb_i[i];
            req[i].we  = bus.m_we_i[i];
            req[i].sel = bus.m_sel_i[4*i +: 4];
            req[i].adr = bus.m_adr_i[32*i +: 32];
            req[i].dat = bus.m_dat_i[32*i +: 32];
            req[i].tga = TAG_MAX'(bus.m_tga_i[TAGSIZE*i +: TAGSIZE]);
            req[i].tgc = TAG_MAX'(bus.m_tgc_i[TAGSIZE*i +: TAGSIZE]);
            req[i].tgd = TAG_MAX'(bus.m_tgd_i[TAGSIZE*i +: TAGSIZE]);
        end
    end

    assign cur     = req[grant_idx];
    assign rsp     = '{dat: bus.s_dat_i, tgd: TAG_MAX'(bus.s_tgd_i),
                       ack: bus.s_ack_i, err: bus.s_err_i, rty: bus.s_rty_i};
    assign any_rsp = rsp.ack | rsp.err | rsp.rty;

    // Fires on the TIMEOUT-th consecutive unanswered strobe cycle.
    assign wd_fire = (state == ST_GRANT) && cur.stb && (wd_cnt == WDW'(TIMEOUT - 1));

    rr_picker #(.N(N_MASTERS), .IDXW(IDXW)) u_picker (
        .req      (bus.m_cyc_i),
        .last_idx (last_idx),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            last_idx  <= IDXW'(N_MASTERS - 1);
            wd_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_nxt;
            last_idx  <= last_nxt;
            wd_cnt    <= wd_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_idx;
        last_nxt    = last_idx;
        wd_nxt      = '0;
        bus.gnt_o   = '0;
        bus.busy_o  = 1'b0;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_sel_o = '0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_tga_o = '0;
        bus.s_tgc_o = '0;
        bus.s_tgd_o = '0;
        bus.m_dat_o = '0;
        bus.m_tgd_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_rty_o = '0;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = pick_idx;
                end
            end
            ST_GRANT: begin
                bus.busy_o             = 1'b1;
                bus.gnt_o[grant_idx]   = 1'b1;
                bus.s_cyc_o            = cur.cyc;
                bus.s_stb_o            = cur.stb & ~wd_fire;
                bus.s_we_o             = cur.we;
                bus.s_sel_o            = cur.sel;
                bus.s_adr_o            = cur.adr;
                bus.s_dat_o            = cur.dat;
                bus.s_tga_o            = TAGSIZE'(cur.tga);
                bus.s_tgc_o            = TAGSIZE'(cur.tgc);
                bus.s_tgd_o            = TAGSIZE'(cur.tgd);
                bus.m_dat_o            = rsp.dat;
                bus.m_tgd_o            = TAGSIZE'(rsp.tgd);
                bus.m_ack_o[grant_idx] = rsp.ack;
                bus.m_err_o[grant_idx] = rsp.err | wd_fire;
                bus.m_rty_o[grant_idx] = rsp.rty;

                if (cur.stb && !any_rsp && !wd_fire) begin
                    wd_nxt = wd_cnt + 1'b1;
                end
                if (!cur.cyc) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = grant_idx;
                    wd_nxt    = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end
endmodule
